// File: rtl/cnn_layer_sequencer_if.sv
// Avalon-MM register bus and datapath block handshake of the CNN layer sequencer.
// The master side is the host/datapath; the slave side is the sequencer.
interface cnn_layer_sequencer_if;
    logic        chipselect;
    logic        write;
    logic        read;
    logic [2:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [1:0]  layer_sel;
    logic        layer_start;
    logic        block_req;
    logic        block_done;
    logic        busy;
    logic        irq;

    modport master (
        output chipselect,
        output write,
        output read,
        output address,
        output writedata,
        output block_done,
        input  readdata,
        input  layer_sel,
        input  layer_start,
        input  block_req,
        input  busy,
        input  irq
    );

    modport slave (
        input  chipselect,
        input  write,
        input  read,
        input  address,
        input  writedata,
        input  block_done,
        output readdata,
        output layer_sel,
        output layer_start,
        output block_req,
        output busy,
        output irq
    );
endinterface

// File: rtl/cnn_layer_sequencer.sv
// Host-programmable scheduler stepping the CNN accelerator through its four layers,
// issuing one block request at a time and flagging completion, aborts and errors.
module cnn_layer_sequencer #(
    parameter int TIMEOUT = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    cnn_layer_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      state_next;

    logic [15:0] layer_blocks [4];
    logic [15:0] block_cnt;
    logic [15:0] cnt_inc;
    logic [15:0] cur_blocks;
    logic [15:0] wd_cnt;
    logic [1:0]  layer_sel;
    logic        done;
    logic        aborted;
    logic        err_timeout;
    logic        err_protocol;
    logic        irq_en;
    logic        busy_int;

    logic        wr_en;
    logic        rd_en;
    logic        ctrl_wr;
    logic        blk_wr;
    logic        start_cmd;
    logic        abort_cmd;
    logic        irq_clear_cmd;
    logic        wd_expire;
    logic [2:0]  blk_addr;
    logic [31:0] read_mux;
    logic [31:0] readdata_q;
    logic        unused_wdata;

    assign wr_en         = bus.chipselect & bus.write;
    assign rd_en         = bus.chipselect & bus.read;
    assign ctrl_wr       = wr_en && (bus.address == 3'd0);
    assign blk_addr      = bus.address - 3'd2;
    assign busy_int      = (state != S_IDLE);

    // Layer counts are frozen while a sequence runs so the terminal compare stays stable.
    assign blk_wr        = wr_en && (bus.address >= 3'd2) && (bus.address <= 3'd5) && !busy_int;

    // Abort beats start when both arrive in the same write; start only counts when idle.
    assign abort_cmd     = ctrl_wr & bus.writedata[1];
    assign start_cmd     = ctrl_wr & bus.writedata[0] & ~bus.writedata[1] & ~busy_int;
    assign irq_clear_cmd = ctrl_wr & bus.writedata[2];

    assign cur_blocks    = layer_blocks[layer_sel];
    assign cnt_inc       = block_cnt + 16'd1;
    assign unused_wdata  = ^bus.writedata[31:16];

    always_comb begin
        read_mux = '0;
        case (bus.address)
            3'd1: read_mux = {block_cnt, 8'd0, layer_sel, 1'b0, err_protocol,
                              err_timeout, aborted, done, busy_int};
            3'd2, 3'd3, 3'd4, 3'd5: read_mux = {16'd0, layer_blocks[blk_addr[1:0]]};
            default: read_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        wd_expire  = 1'b0;
        if (abort_cmd) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_cmd) begin
                        state_next = S_LOAD;
                    end
                end
                S_LOAD: begin
                    state_next = (cur_blocks == 16'd0) ? S_NEXT : S_ISSUE;
                end
                S_ISSUE: begin
                    state_next = S_WAIT;
                end
                S_WAIT: begin
                    // A completion arriving on the expiry cycle still counts as a normal block.
                    if (bus.block_done) begin
                        state_next = (cnt_inc == cur_blocks) ? S_NEXT : S_ISSUE;
                    end else if (wd_cnt == WD_LIMIT) begin
                        state_next = S_IDLE;
                        wd_expire  = 1'b1;
                    end
                end
                S_NEXT: begin
                    state_next = (layer_sel == 2'd3) ? S_DONE : S_LOAD;
                end
                S_DONE: begin
                    state_next = S_IDLE;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                layer_blocks[i] <= '0;
            end
            block_cnt    <= '0;
            wd_cnt       <= '0;
            layer_sel    <= '0;
            done         <= 1'b0;
            aborted      <= 1'b0;
            err_timeout  <= 1'b0;
            err_protocol <= 1'b0;
            irq_en       <= 1'b0;
            readdata_q   <= '0;
        end else begin
            if (ctrl_wr) begin
                irq_en <= bus.writedata[3];
            end
            if (blk_wr) begin
                layer_blocks[blk_addr[1:0]] <= bus.writedata[15:0];
            end
            if (rd_en) begin
                readdata_q <= read_mux;
            end

            if (start_cmd) begin
                layer_sel    <= '0;
                done         <= 1'b0;
                aborted      <= 1'b0;
                err_timeout  <= 1'b0;
                err_protocol <= 1'b0;
            end

            // On abort layer_sel and block_cnt freeze so the host can see where it stopped.
            if (!abort_cmd) begin
                if (state == S_LOAD && cur_blocks != 16'd0) begin
                    block_cnt <= '0;
                end
                if (state == S_WAIT && bus.block_done) begin
                    block_cnt <= cnt_inc;
                end
                if (state == S_NEXT && layer_sel != 2'd3) begin
                    layer_sel <= layer_sel + 2'd1;
                end
            end

            if (state_next == S_WAIT && state != S_WAIT) begin
                wd_cnt <= '0;
            end else if (state == S_WAIT) begin
                wd_cnt <= wd_cnt + 16'd1;
            end

            // done rises together with DONE so irq is visible there; completion beats irq_clear.
            if (irq_clear_cmd) begin
                done <= 1'b0;
            end
            if (state_next == S_DONE || (state == S_DONE && !abort_cmd)) begin
                done <= 1'b1;
            end
            if (abort_cmd) begin
                aborted <= 1'b1;
            end
            if (wd_expire) begin
                err_timeout <= 1'b1;
            end
            if (bus.block_done && state != S_WAIT) begin
                err_protocol <= 1'b1;
            end
        end
    end

    assign bus.readdata    = readdata_q;
    assign bus.layer_sel   = layer_sel;
    assign bus.layer_start = (state == S_LOAD) && (cur_blocks != 16'd0);
    assign bus.block_req   = (state == S_ISSUE);
    assign bus.busy        = busy_int;
    assign bus.irq         = done & irq_en;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed self-checking bench for cnn_layer_sequencer; plays both host and datapath,
// with a short watchdog so timeout behaviour is reachable quickly.
module tb_cnn_layer_sequencer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    cnn_layer_sequencer_if bus();

    cnn_layer_sequencer #(.TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          assert_count = 0;
    int          fail_count   = 0;
    int          cycle_count  = 0;
    int          req_count;
    int          start_count;
    int          done_cd;
    int          last_fire_cycle;
    int          last_req_cycle;
    int          irq_rise_cycle;
    bit          auto_done;
    logic [1:0]  start_log [8];
    int          start_gap [8];
    logic [31:0] rd_val;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One clock: outputs are observed 1 ns after the edge, and the datapath model answers
    // each block_req with a block_done three cycles later when auto_done is set.
    task automatic tick();
        logic fire;
        @(posedge clk);
        #1;
        cycle_count++;
        fire = 1'b0;
        if (done_cd > 0) begin
            done_cd--;
            fire = (done_cd == 0);
        end
        bus.block_done = fire;
        if (fire) last_fire_cycle = cycle_count;
        if (bus.block_req) begin
            req_count++;
            last_req_cycle = cycle_count;
            if (auto_done) done_cd = 3;
        end
        if (bus.layer_start && start_count < 8) begin
            start_log[start_count] = bus.layer_sel;
            start_gap[start_count] = cycle_count - last_fire_cycle;
            start_count++;
        end
        if (bus.irq && irq_rise_cycle < 0) irq_rise_cycle = cycle_count;
    endtask

    task automatic clear_log();
        req_count       = 0;
        start_count     = 0;
        done_cd         = 0;
        last_fire_cycle = 0;
        last_req_cycle  = 0;
        irq_rise_cycle  = -1;
    endtask

    task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] data);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = addr;
        bus.writedata  = data;
        tick();
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] addr, output logic [31:0] data);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = addr;
        tick();
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        data           = bus.readdata;
    endtask

    task automatic program_layers(input logic [15:0] b0, input logic [15:0] b1,
                                  input logic [15:0] b2, input logic [15:0] b3);
        applyStimulus(3'd2, {16'd0, b0});
        applyStimulus(3'd3, {16'd0, b1});
        applyStimulus(3'd4, {16'd0, b2});
        applyStimulus(3'd5, {16'd0, b3});
    endtask

    task automatic wait_idle(input string tag, input int bound);
        for (int n = 0; n < bound && bus.busy; n++) tick();
        checkOutput(tag, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        reset          = 1'b1;
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.read       = 1'b0;
        bus.address    = '0;
        bus.writedata  = '0;
        bus.block_done = 1'b0;
        auto_done      = 1'b0;
        clear_log();

        repeat (3) tick();
        checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("reset_irq", {31'd0, bus.irq}, 32'd0);
        checkOutput("reset_layer_sel", {30'd0, bus.layer_sel}, 32'd0);
        checkOutput("reset_readdata", bus.readdata, 32'd0);
        reset = 1'b0;
        tick();
        bus_read(3'd1, rd_val);
        checkOutput("reset_status", rd_val, 32'd0);

        // Full run {4,2,3,1}
        program_layers(16'd4, 16'd2, 16'd3, 16'd1);
        bus_read(3'd4, rd_val);
        checkOutput("layer2_readback", rd_val, 32'd3);
        clear_log();
        auto_done = 1'b1;
        applyStimulus(3'd0, 32'h9);
        checkOutput("load_layer_start", {31'd0, bus.layer_start}, 32'd1);
        checkOutput("load_busy", {31'd0, bus.busy}, 32'd1);
        tick();
        checkOutput("first_block_req", {31'd0, bus.block_req}, 32'd1);
        wait_idle("full_run_finish", 400);
        checkOutput("full_req_count", req_count, 32'd10);
        checkOutput("full_start_count", start_count, 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("full_start_layer%0d", i), {30'd0, start_log[i]}, i);
        end
        checkOutput("next_layer_start_gap", start_gap[1], 32'd2);
        checkOutput("irq_latency", irq_rise_cycle - last_fire_cycle, 32'd2);
        checkOutput("full_irq", {31'd0, bus.irq}, 32'd1);
        bus_read(3'd1, rd_val);
        checkOutput("full_status", rd_val, 32'h0001_00C2);

        // Skipped layers {0,2,0,1}, plus irq_clear landing in DONE
        program_layers(16'd0, 16'd2, 16'd0, 16'd1);
        clear_log();
        applyStimulus(3'd0, 32'h9);
        checkOutput("start_clears_done", {31'd0, bus.irq}, 32'd0);
        for (int n = 0; n < 200 && !bus.irq; n++) tick();
        checkOutput("skip_irq_seen", {31'd0, bus.irq}, 32'd1);
        checkOutput("skip_done_state_busy", {31'd0, bus.busy}, 32'd1);
        applyStimulus(3'd0, 32'hC);
        checkOutput("irq_clear_in_done", {31'd0, bus.irq}, 32'd1);
        checkOutput("skip_req_count", req_count, 32'd3);
        checkOutput("skip_start_count", start_count, 32'd2);
        checkOutput("skip_start0_layer", {30'd0, start_log[0]}, 32'd1);
        checkOutput("skip_start1_layer", {30'd0, start_log[1]}, 32'd3);
        bus_read(3'd1, rd_val);
        checkOutput("skip_status", rd_val, 32'h0001_00C2);
        applyStimulus(3'd0, 32'hC);
        checkOutput("irq_clear_idle", {31'd0, bus.irq}, 32'd0);

        // Abort in layer 1 WAIT after its first block
        program_layers(16'd1, 16'd2, 16'd1, 16'd1);
        clear_log();
        applyStimulus(3'd0, 32'h9);
        for (int n = 0; n < 200 && req_count < 3; n++) tick();
        checkOutput("abort_reach_block2", req_count, 32'd3);
        auto_done = 1'b0;
        done_cd   = 0;
        tick();
        applyStimulus(3'd0, 32'hA);
        checkOutput("abort_busy", {31'd0, bus.busy}, 32'd0);
        repeat (8) tick();
        checkOutput("abort_no_more_req", req_count, 32'd3);
        checkOutput("abort_irq", {31'd0, bus.irq}, 32'd0);
        bus_read(3'd1, rd_val);
        checkOutput("abort_status", rd_val, 32'h0001_0044);

        // Watchdog expiry with no block_done
        program_layers(16'd1, 16'd0, 16'd0, 16'd0);
        clear_log();
        applyStimulus(3'd0, 32'h9);
        wait_idle("timeout_exit", 100);
        checkOutput("timeout_wait_cycles", cycle_count - last_req_cycle - 1, 32'd16);
        checkOutput("timeout_irq", {31'd0, bus.irq}, 32'd0);
        bus_read(3'd1, rd_val);
        checkOutput("timeout_status", rd_val, 32'h0000_0008);

        // Writes ignored while busy, block_done on the expiry cycle, stray block_done
        program_layers(16'd2, 16'd0, 16'd0, 16'd0);
        clear_log();
        applyStimulus(3'd0, 32'h9);
        applyStimulus(3'd2, 32'd7);
        applyStimulus(3'd0, 32'h9);
        while (cycle_count < last_req_cycle + 16) tick();
        bus.block_done = 1'b1;
        tick();
        checkOutput("done_at_expiry_counts", {31'd0, bus.block_req}, 32'd1);
        tick();
        bus.block_done = 1'b1;
        tick();
        wait_idle("busy_writes_finish", 50);
        checkOutput("busy_writes_req_count", req_count, 32'd2);
        bus_read(3'd1, rd_val);
        checkOutput("busy_writes_status", rd_val, 32'h0002_00C2);
        bus_read(3'd2, rd_val);
        checkOutput("busy_write_ignored", rd_val, 32'd2);
        bus.block_done = 1'b1;
        tick();
        bus_read(3'd1, rd_val);
        checkOutput("stray_done_status", rd_val, 32'h0002_00D2);

        // Reset during layer 2, then a clean rerun
        program_layers(16'd1, 16'd1, 16'd5, 16'd1);
        clear_log();
        auto_done = 1'b1;
        applyStimulus(3'd0, 32'h9);
        for (int n = 0; n < 200 && start_count < 3; n++) tick();
        checkOutput("reach_layer2", start_count, 32'd3);
        repeat (4) tick();
        bus_read(3'd1, rd_val);
        checkOutput("mid_layer2_sel", {30'd0, rd_val[7:6]}, 32'd2);
        auto_done = 1'b0;
        done_cd   = 0;
        reset     = 1'b1;
        tick();
        checkOutput("midreset_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("midreset_layer_sel", {30'd0, bus.layer_sel}, 32'd0);
        checkOutput("midreset_readdata", bus.readdata, 32'd0);
        checkOutput("midreset_pulses", {30'd0, bus.layer_start, bus.block_req}, 32'd0);
        reset = 1'b0;
        tick();
        bus_read(3'd4, rd_val);
        checkOutput("midreset_cfg_cleared", rd_val, 32'd0);
        program_layers(16'd0, 16'd0, 16'd2, 16'd0);
        clear_log();
        auto_done = 1'b1;
        applyStimulus(3'd0, 32'h9);
        wait_idle("rerun_finish", 200);
        checkOutput("rerun_req_count", req_count, 32'd2);
        checkOutput("rerun_start_count", start_count, 32'd1);
        checkOutput("rerun_start_layer", {30'd0, start_log[0]}, 32'd2);
        checkOutput("rerun_irq", {31'd0, bus.irq}, 32'd1);
        bus_read(3'd1, rd_val);
        checkOutput("rerun_status", rd_val, 32'h0002_00C2);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
